// File: rtl/trig_sampler_pkg.sv
// Trigger-mode codes and FSM state encoding shared by trig_sampler and trig_detect.
package trig_sampler_pkg;

   localparam logic [1:0] TRIG_IMMEDIATE  = 2'd0;
   localparam logic [1:0] TRIG_GATE_RISE  = 2'd1;
   localparam logic [1:0] TRIG_GATE_FALL  = 2'd2;
   localparam logic [1:0] TRIG_LEVEL_RISE = 2'd3;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PRE       = 3'd1;
   localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
   localparam logic [2:0] ST_POST      = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      PRE       = ST_PRE,
      WAIT_TRIG = ST_WAIT_TRIG,
      POST      = ST_POST,
      DONE      = ST_DONE
   } state_t;

endpackage

// File: rtl/trig_sampler_trig_detect.sv
// Trigger qualifier: gate edge detect with pending flag, channel mux and signed
// level-crossing compare, reduced to one trig_hit on each armed strobe.
module trig_detect
   import trig_sampler_pkg::*;
#(
   parameter int NUM_CHANNELS = 2,
   parameter int DATA_SIZE    = 14,
   parameter int CH_W         = 1
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 clear,
   input  logic                                 strobe,
   input  logic                                 arm,
   input  logic [1:0]                           mode,
   input  logic [CH_W-1:0]                      channel,
   input  logic signed [DATA_SIZE-1:0]          level,
   input  logic                                 gate,
   input  logic [NUM_CHANNELS-1:0][DATA_SIZE-1:0] data,
   output logic                                 trig_hit
);

   logic gate_q, pending, edge_now, prev_vld, level_hit, gate_mode;
   logic signed [DATA_SIZE-1:0] sel, prev;

   always_comb begin
      edge_now = 1'b0;
      if (mode == TRIG_GATE_RISE)      edge_now = gate & ~gate_q;
      else if (mode == TRIG_GATE_FALL) edge_now = ~gate & gate_q;
   end

   always_comb begin
      sel = '0;
      if (32'(channel) < NUM_CHANNELS) sel = data[channel];
   end

   assign gate_mode = (mode == TRIG_GATE_RISE) || (mode == TRIG_GATE_FALL);
   assign level_hit = prev_vld && (prev < level) && (sel >= level);
   assign trig_hit  = arm && ((mode == TRIG_IMMEDIATE) ||
                              (gate_mode && (edge_now || pending)) ||
                              ((mode == TRIG_LEVEL_RISE) && level_hit));

   // An edge seen between strobes is held until the next armed strobe consumes it.
   always_ff @(posedge clock) begin
      if (reset) begin
         gate_q   <= 1'b0;
         pending  <= 1'b0;
         prev     <= '0;
         prev_vld <= 1'b0;
      end else begin
         gate_q <= gate;
         if (clear || arm)  pending <= 1'b0;
         else if (edge_now) pending <= 1'b1;
         if (clear) prev_vld <= 1'b0;
         else if (strobe) begin
            prev     <= sel;
            prev_vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/trig_sampler.sv
// Multi-channel triggered acquisition engine with circular pre-trigger buffer.
// Optional auto-trigger timeout is built when TRIG_TIMEOUT_EN is defined.
module trig_sampler
   import trig_sampler_pkg::*;
#(
   parameter int  NUM_CHANNELS   = 2,
   parameter int  DATA_SIZE      = 14,
   parameter int  SAMPLE_SIZE    = 16,
   parameter int  ADDR_SIZE      = 13,
   parameter int  DECIMATOR_SIZE = 4,
   parameter int  TIMEOUT_CYCLES = 1000000,
   localparam int CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic [NUM_CHANNELS*DATA_SIZE-1:0]   i_data,
   input  logic                                i_gate,
   input  logic                                i_start,
   input  logic                                i_abort,
   input  logic [ADDR_SIZE-1:0]                i_memory_size,
   input  logic [ADDR_SIZE-1:0]                i_pretrig,
   input  logic [DECIMATOR_SIZE-1:0]           i_decimator,
   input  logic [1:0]                          i_trig_mode,
   input  logic [CH_W-1:0]                     i_trig_channel,
   input  logic signed [DATA_SIZE-1:0]         i_trig_level,
   output logic                                o_wr_en,
   output logic [ADDR_SIZE-1:0]                o_addr,
   output logic [NUM_CHANNELS*SAMPLE_SIZE-1:0] o_data,
   output logic [ADDR_SIZE-1:0]                o_trig_addr,
   output logic [ADDR_SIZE-1:0]                o_start_addr,
   output logic                                o_busy,
   output logic                                o_end,
   output logic                                o_timed_out
);

   state_t state, state_nxt;
   logic [ADDR_SIZE-1:0] size_q, pretrig_q, size_in, pretrig_in, post_lim;
   logic [ADDR_SIZE-1:0] wr_addr, pre_cnt, post_cnt, trig_start;
   logic [DECIMATOR_SIZE-1:0] decim_q, dec_cnt;
   logic [1:0] mode_q;
   logic [CH_W-1:0] chan_q;
   logic signed [DATA_SIZE-1:0] level_q;
   logic start, acq, strobe, arm, hit, to_pend, fire;
   logic [NUM_CHANNELS-1:0][DATA_SIZE-1:0]   data_ch;
   logic [NUM_CHANNELS-1:0][SAMPLE_SIZE-1:0] data_ext;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("trig_sampler: TIMEOUT_CYCLES must be at least 1");
   end

   assign data_ch = i_data;
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ext
      assign data_ext[c] = SAMPLE_SIZE'($signed(data_ch[c]));
   end

   assign size_in    = (i_memory_size < ADDR_SIZE'(2)) ? ADDR_SIZE'(2) : i_memory_size;
   assign pretrig_in = (i_pretrig > size_in - ADDR_SIZE'(1)) ? size_in - ADDR_SIZE'(1) : i_pretrig;
   assign start      = (state == IDLE) && i_start;
   assign acq        = state inside {PRE, WAIT_TRIG, POST};
   assign strobe     = acq && (dec_cnt == '0);
   // With no pre-trigger window the very first strobe is already a trigger candidate.
   assign arm        = strobe && ((state == WAIT_TRIG) || ((state == PRE) && (pretrig_q == '0)));
   assign fire       = hit || (arm && to_pend);
   assign post_lim   = size_q - pretrig_q;
   assign trig_start = (wr_addr >= pretrig_q) ? wr_addr - pretrig_q : wr_addr + post_lim;
   assign o_busy     = (state != IDLE);

   trig_detect #(
      .NUM_CHANNELS(NUM_CHANNELS),
      .DATA_SIZE   (DATA_SIZE),
      .CH_W        (CH_W)
   ) u_trig_detect (
      .clock   (i_clock),
      .reset   (i_reset),
      .clear   (start),
      .strobe  (strobe),
      .arm     (arm),
      .mode    (mode_q),
      .channel (chan_q),
      .level   (level_q),
      .gate    (i_gate),
      .data    (data_ch),
      .trig_hit(hit)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (i_start) state_nxt = PRE;
         PRE:       if (strobe) begin
                       if (pretrig_q == '0)
                          state_nxt = fire ? POST : WAIT_TRIG;
                       else if (pre_cnt + ADDR_SIZE'(1) == pretrig_q)
                          state_nxt = WAIT_TRIG;
                    end
         WAIT_TRIG: if (fire) state_nxt = (post_lim == ADDR_SIZE'(1)) ? DONE : POST;
         POST:      if (strobe && (post_cnt + ADDR_SIZE'(1) == post_lim)) state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (i_abort && (state != IDLE)) state_nxt = IDLE;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state        <= IDLE;
         size_q       <= ADDR_SIZE'(2);
         pretrig_q    <= '0;
         decim_q      <= '0;
         mode_q       <= '0;
         chan_q       <= '0;
         level_q      <= '0;
         wr_addr      <= '0;
         dec_cnt      <= '0;
         pre_cnt      <= '0;
         post_cnt     <= '0;
         o_wr_en      <= 1'b0;
         o_addr       <= '0;
         o_data       <= '0;
         o_trig_addr  <= '0;
         o_start_addr <= '0;
         o_end        <= 1'b0;
      end else begin
         state   <= state_nxt;
         o_wr_en <= strobe && !i_abort;
         o_end   <= (state == DONE) && !i_abort;
         if (strobe && !i_abort) begin
            o_addr  <= wr_addr;
            o_data  <= data_ext;
            wr_addr <= (wr_addr == size_q - ADDR_SIZE'(1)) ? '0 : wr_addr + ADDR_SIZE'(1);
         end
         if (acq) dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DECIMATOR_SIZE'(1);
         if ((state == PRE) && strobe)  pre_cnt  <= pre_cnt + ADDR_SIZE'(1);
         if ((state == POST) && strobe) post_cnt <= post_cnt + ADDR_SIZE'(1);
         if (fire && !i_abort) begin
            o_trig_addr  <= wr_addr;
            o_start_addr <= trig_start;
            post_cnt     <= ADDR_SIZE'(1);
         end
         if (start) begin
            size_q       <= size_in;
            pretrig_q    <= pretrig_in;
            decim_q      <= i_decimator;
            mode_q       <= i_trig_mode;
            chan_q       <= i_trig_channel;
            level_q      <= i_trig_level;
            wr_addr      <= '0;
            dec_cnt      <= '0;
            pre_cnt      <= '0;
            o_trig_addr  <= '0;
            o_start_addr <= '0;
         end
      end
   end

`ifdef TRIG_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            to_flag;

   // Once the window expires the next armed strobe is forced to trigger.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         to_cnt  <= '0;
         to_pend <= 1'b0;
         to_flag <= 1'b0;
      end else begin
         if (start) begin
            to_cnt  <= '0;
            to_pend <= 1'b0;
            to_flag <= 1'b0;
         end else if ((state == WAIT_TRIG) && !to_pend) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) to_pend <= 1'b1;
            else                                     to_cnt  <= to_cnt + TO_W'(1);
         end
         if (fire && !hit && !i_abort) to_flag <= 1'b1;
      end
   end
   assign o_timed_out = to_flag;
`else
   assign to_pend     = 1'b0;
   assign o_timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_trig_sampler.sv
// Directed bench for trig_sampler: one task per scenario, inline checks against hand-derived values.
module tb_trig_sampler;
   localparam int NC = 2, DS = 14, AS = 13, DW = 4;
`ifdef TRIG_TIMEOUT_EN
   localparam int TO = 50;
`else
   localparam int TO = 1000000;
`endif

   logic clk = 1'b0, rst = 1'b1, gate = 1'b0, start = 1'b0, abort = 1'b0;
   logic [NC*DS-1:0] data = '0;
   logic [AS-1:0] msize = '0, pretrig = '0;
   logic [DW-1:0] decim = '0;
   logic [1:0] tmode = '0;
   logic [0:0] tchan = '0;
   logic [DS-1:0] tlevel = '0;
   logic wr_en, busy, endp, timed_out;
   logic [AS-1:0] addr, trig_addr, start_addr;
   logic [31:0] odata;

   int cyc = 0, start_cyc = 0, base_cyc = 0, gen_mode = 0;
   int pass_cnt = 0, total_cnt = 0, end_cnt = 0, end_cyc = 0;
   int wa[$], wc[$];
   logic [31:0] wd[$];

   trig_sampler #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clock(clk), .i_reset(rst), .i_data(data), .i_gate(gate), .i_start(start),
      .i_abort(abort), .i_memory_size(msize), .i_pretrig(pretrig), .i_decimator(decim),
      .i_trig_mode(tmode), .i_trig_channel(tchan), .i_trig_level(tlevel),
      .o_wr_en(wr_en), .o_addr(addr), .o_data(odata), .o_trig_addr(trig_addr),
      .o_start_addr(start_addr), .o_busy(busy), .o_end(endp), .o_timed_out(timed_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en) begin
         wa.push_back(int'(addr));
         wd.push_back(odata);
         wc.push_back(cyc);
      end
      if (endp) begin
         end_cnt = end_cnt + 1;
         end_cyc = cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
      $fatal(1);
   end

   // Ramp word as the DUT should store it: ch0 = v, ch1 = -v, both 16-bit two's complement.
   function automatic logic [31:0] ramp_word(int c);
      int v;
      v = c % 1000;
      return {16'(-v), 16'(v)};
   endfunction

   task automatic tick();
      @(negedge clk);
      if (gen_mode == 0) data = {DS'(-(cyc % 1000)), DS'(cyc % 1000)};
      else               data = {DS'(-50 + cyc - base_cyc), DS'(-8192)};
   endtask

   task automatic start_rec(int sz, int pt, int dc, int md, int ch, int lv);
      tick();
      msize = AS'(sz); pretrig = AS'(pt); decim = DW'(dc);
      tmode = 2'(md); tchan = 1'(ch); tlevel = DS'(lv);
      wa.delete(); wd.delete(); wc.delete();
      end_cnt = 0;
      start = 1'b1;
      start_cyc = cyc;
      base_cyc = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(int budget, string name);
      int n;
      n = 0;
      while (end_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      repeat (3) tick();
      total_cnt++;
      if (end_cnt !== 1) $display("FAIL %s_end_count: got %0d required 1", name, end_cnt);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      total_cnt++;
      if ({wr_en, busy, endp, timed_out} !== 4'b0) $display("FAIL reset_flags: got %b required 0000", {wr_en, busy, endp, timed_out});
      else pass_cnt++;
      total_cnt++;
      if ({addr, trig_addr, start_addr, odata} !== '0) $display("FAIL reset_buses: got %0h required 0", {addr, trig_addr, start_addr, odata});
      else pass_cnt++;
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_immediate();
      gen_mode = 0;
      start_rec(8, 0, 0, 0, 0, 0);
      wait_end(40, "imm");
      total_cnt++;
      if (wa.size() !== 8) $display("FAIL imm_writes: got %0d required 8", wa.size());
      else pass_cnt++;
      for (int i = 0; i < 8 && i < wa.size(); i++) begin
         total_cnt++;
         if (wa[i] !== i || wc[i] !== start_cyc + 2 + i || wd[i] !== ramp_word(start_cyc + 1 + i))
            $display("FAIL imm_write%0d: got addr %0d cyc %0d data %h required addr %0d cyc %0d data %h",
                     i, wa[i], wc[i], wd[i], i, start_cyc + 2 + i, ramp_word(start_cyc + 1 + i));
         else pass_cnt++;
      end
      total_cnt++;
      if (trig_addr !== 0 || start_addr !== 0) $display("FAIL imm_addrs: got trig %0d start %0d required 0 0", trig_addr, start_addr);
      else pass_cnt++;
      total_cnt++;
      if (end_cyc !== start_cyc + 10 || busy !== 1'b0) $display("FAIL imm_end_timing: got cyc %0d busy %b required %0d 0", end_cyc, busy, start_cyc + 10);
      else pass_cnt++;
   endtask

   task automatic test_decim();
      gen_mode = 0;
      start_rec(4, 0, 3, 0, 0, 0);
      wait_end(60, "decim");
      total_cnt++;
      if (wa.size() !== 4) $display("FAIL decim_writes: got %0d required 4", wa.size());
      else pass_cnt++;
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         total_cnt++;
         if (wa[i] !== i || wc[i] !== start_cyc + 2 + 4 * i || wd[i] !== ramp_word(start_cyc + 1 + 4 * i))
            $display("FAIL decim_write%0d: got addr %0d cyc %0d data %h required addr %0d cyc %0d data %h",
                     i, wa[i], wc[i], wd[i], i, start_cyc + 2 + 4 * i, ramp_word(start_cyc + 1 + 4 * i));
         else pass_cnt++;
      end
      total_cnt++;
      if (end_cyc !== start_cyc + 15) $display("FAIL decim_end_cyc: got %0d required %0d", end_cyc, start_cyc + 15);
      else pass_cnt++;
   endtask

   task automatic test_clamp();
      gen_mode = 0;
      start_rec(1, 5, 0, 0, 0, 0);
      wait_end(20, "clamp");
      total_cnt++;
      if (wa.size() !== 2 || trig_addr !== 1 || start_addr !== 0)
         $display("FAIL clamp_record: got writes %0d trig %0d start %0d required 2 1 0", wa.size(), trig_addr, start_addr);
      else pass_cnt++;
      total_cnt++;
      if (end_cyc !== start_cyc + 4) $display("FAIL clamp_end_cyc: got %0d required %0d", end_cyc, start_cyc + 4);
      else pass_cnt++;
   endtask

   task automatic test_pretrig_gate();
      gen_mode = 0;
      start_rec(8, 3, 0, 1, 0, 0);
      repeat (20) tick();
      gate = 1'b1;
      wait_end(40, "gate");
      gate = 1'b0;
      total_cnt++;
      if (wa.size() !== 25) $display("FAIL gate_writes: got %0d required 25", wa.size());
      else pass_cnt++;
      total_cnt++;
      if (wa.size() == 25 && (wa[8] !== 0 || wa[20] !== 4 || wa[24] !== 0))
         $display("FAIL gate_wrap: got %0d %0d %0d required 0 4 0", wa[8], wa[20], wa[24]);
      else pass_cnt++;
      total_cnt++;
      if (trig_addr !== 4 || start_addr !== 1) $display("FAIL gate_addrs: got trig %0d start %0d required 4 1", trig_addr, start_addr);
      else pass_cnt++;
   endtask

   task automatic test_level();
      gen_mode = 1;
      start_rec(8, 2, 0, 3, 1, 100);
      wait_end(300, "level");
      total_cnt++;
      if (wa.size() !== 156) $display("FAIL level_writes: got %0d required 156", wa.size());
      else pass_cnt++;
      total_cnt++;
      if (trig_addr !== 6 || start_addr !== 4) $display("FAIL level_addrs: got trig %0d start %0d required 6 4", trig_addr, start_addr);
      else pass_cnt++;
      total_cnt++;
      if (wa.size() > 150 && (wd[150] !== 32'h0064_E000 || wa[150] !== 6))
         $display("FAIL level_trig_word: got %h at %0d required 0064e000 at 6", wd[150], wa[150]);
      else pass_cnt++;
      total_cnt++;
      if (wa.size() > 0 && wd[0] !== 32'hFFCE_E000) $display("FAIL level_first_word: got %h required ffcee000", wd[0]);
      else pass_cnt++;
      gen_mode = 0;
   endtask

   task automatic test_abort();
      gen_mode = 0;
      start_rec(8, 0, 0, 0, 0, 0);
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total_cnt++;
      if (wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL abort_stop: got wr_en %b busy %b required 0 0", wr_en, busy);
      else pass_cnt++;
      repeat (12) tick();
      total_cnt++;
      if (wa.size() !== 2 || end_cnt !== 0) $display("FAIL abort_record: got writes %0d ends %0d required 2 0", wa.size(), end_cnt);
      else pass_cnt++;
      start_rec(8, 0, 0, 0, 0, 0);
      wait_end(40, "abort_rerun");
      total_cnt++;
      if (wa.size() !== 8 || wa[7] !== 7) $display("FAIL abort_rerun: got writes %0d required 8 ending at 7", wa.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      gen_mode = 0;
      start_rec(8, 5, 0, 1, 0, 0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || addr !== 0) $display("FAIL rstmid_stop: got wr_en %b busy %b addr %0d required 0 0 0", wr_en, busy, addr);
      else pass_cnt++;
      repeat (8) tick();
      total_cnt++;
      if (wa.size() !== 2 || end_cnt !== 0) $display("FAIL rstmid_record: got writes %0d ends %0d required 2 0", wa.size(), end_cnt);
      else pass_cnt++;
      start_rec(8, 0, 0, 0, 0, 0);
      wait_end(40, "rstmid_rerun");
      total_cnt++;
      if (wa.size() !== 8 || trig_addr !== 0) $display("FAIL rstmid_rerun: got writes %0d trig %0d required 8 0", wa.size(), trig_addr);
      else pass_cnt++;
   endtask

`ifdef TRIG_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      gen_mode = 0;
      start_rec(4, 0, 0, 1, 0, 0);
      wait_end(200, "timeout");
      total_cnt++;
      if (timed_out !== 1'b1) $display("FAIL timeout_flag: got %b required 1", timed_out);
      else pass_cnt++;
      k = (wa.size() >= 4) ? wc[wa.size() - 4] - start_cyc - 2 : -1;
      total_cnt++;
      if (k < 49 || k > 53) $display("FAIL timeout_strobe: got index %0d required 49..53", k);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_immediate();
      test_decim();
      test_clamp();
      test_pretrig_gate();
      test_level();
      test_abort();
      test_reset_mid();
`ifdef TRIG_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
